// File: rtl/uart_loader_pkg.sv
// ============================================================================
// uart_loader_pkg : shared state encoding, default opcodes, timeout sizing
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] DEF_CMD_LOAD    = 8'h80;
    localparam logic [7:0] DEF_CMD_STATUS  = 8'h40;
    localparam logic [7:0] DEF_CMD_READY   = 8'h20;
    localparam logic [7:0] DEF_CMD_CLEAR   = 8'h10;
    localparam int         DEF_TIMEOUT_CYC = 100000;

    // The counter only ever holds 0..cyc-1.
    function automatic int tmo_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_loader_tmo.sv
// ============================================================================
// uart_loader_tmo : inter-byte timeout counter; expired on the TIMEOUT_CYC-th
// consecutive enabled cycle without clr.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_loader_tmo
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = tmo_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && !clr && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_word_loader.sv
// ============================================================================
// uart_word_loader : uart byte-stream command parser feeding a FIFO write port
// Optional checksum byte after the payload when UART_LOADER_CSUM_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int         WORD_BYTES  = 2,
    parameter logic [7:0] CMD_LOAD    = DEF_CMD_LOAD,
    parameter logic [7:0] CMD_STATUS  = DEF_CMD_STATUS,
    parameter logic [7:0] CMD_READY   = DEF_CMD_READY,
    parameter logic [7:0] CMD_CLEAR   = DEF_CMD_CLEAR,
    parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int        DATA_W      = 8 * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] din,
    output logic              status,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        words_left,
    output logic              err_ovf,
    output logic              err_tmo
`ifdef UART_LOADER_CSUM_EN
    ,
    output logic              err_csum
`endif
);

    state_t            state, state_nxt;
    logic [2:0]        byte_idx;
    logic [DATA_W-1:0] word_nxt;
    logic              tmo_exp, last_byte, last_word, word_end;
    logic              wr_nxt, done_nxt, abort;

    assign busy      = (state != ST_IDLE);
    assign last_byte = (byte_idx == 3'(WORD_BYTES - 1));
    assign last_word = (words_left == 8'd1);
    assign word_end  = (state == ST_DATA) && rx_valid && last_byte;

    uart_loader_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid || (state == ST_IDLE)),
        .en      (busy),
        .expired (tmo_exp)
    );

    // Big-endian assembly: earlier bytes sit in the upper bits.
    generate
        if (WORD_BYTES == 1) begin : g_single
            assign word_nxt = rx_byte;
        end else begin : g_multi
            logic [DATA_W-9:0] acc;
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc <= '0;
                end else if ((state == ST_DATA) && rx_valid) begin
                    acc <= word_nxt[DATA_W-9:0];
                end
            end
            assign word_nxt = {acc, rx_byte};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        done_nxt  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == CMD_LOAD)) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else if (tmo_exp) begin
                    abort = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    if (last_byte) begin
                        wr_nxt = !fifo_full;
                        if (last_word) begin
`ifdef UART_LOADER_CSUM_EN
                            state_nxt = ST_CSUM;
`else
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
`endif
                        end
                    end
                end else if (tmo_exp) begin
                    abort = 1'b1;
                end
            end
`ifdef UART_LOADER_CSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (tmo_exp) begin
                    abort = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

`ifdef UART_LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum     <= 8'd0;
            err_csum <= 1'b0;
        end else begin
            if ((state == ST_LEN) && rx_valid)  csum <= rx_byte;
            if ((state == ST_DATA) && rx_valid) csum <= csum ^ rx_byte;
            if ((state == ST_CSUM) && rx_valid && (rx_byte != csum)) err_csum <= 1'b1;
            if ((state == ST_IDLE) && rx_valid && (rx_byte == CMD_CLEAR)) err_csum <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            done       <= 1'b0;
            din        <= '0;
            status     <= 1'b0;
            ready      <= 1'b0;
            words_left <= 8'd0;
            byte_idx   <= 3'd0;
            err_ovf    <= 1'b0;
            err_tmo    <= 1'b0;
        end else begin
            wr_en <= wr_nxt;
            done  <= done_nxt;
            if ((state == ST_IDLE) && rx_valid) begin
                if (rx_byte == CMD_STATUS) status <= 1'b1;
                if (rx_byte == CMD_READY)  ready  <= 1'b1;
                if (rx_byte == CMD_CLEAR) begin
                    status  <= 1'b0;
                    ready   <= 1'b0;
                    err_ovf <= 1'b0;
                    err_tmo <= 1'b0;
                end
            end
            if ((state == ST_LEN) && rx_valid) begin
                words_left <= rx_byte;
                byte_idx   <= 3'd0;
            end
            if ((state == ST_DATA) && rx_valid) begin
                byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
            end
            if (word_end) begin
                words_left <= words_left - 8'd1;
                if (fifo_full) err_ovf <= 1'b1;
                else           din     <= word_nxt;
            end
            if (abort) begin
                err_tmo    <= 1'b1;
                words_left <= 8'd0;
            end
        end
    end

endmodule

`default_nettype wire
